// File: rtl/cpu_bus_responder.sv
// Responder end of the CPU bus (A1/C1/D1) backed by a flat byte-addressed scratchpad.
// Captures a two-cycle command, turns the bus around, commits writes and returns RESPONSE cycles.
module cpu_bus_responder #(
  parameter int MEM_ADDR_BITS = 12,
  parameter int RESP_DELAY    = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [14:0] A1,
  inout  wire  [2:0]  C1,
  inout  wire  [15:0] D1,
  output logic        busy
);

  localparam int MEM_BYTES = 1 << MEM_ADDR_BITS;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_READ8   = 3'd1;
  localparam logic [2:0] CMD_READ16  = 3'd2;
  localparam logic [2:0] CMD_READ32  = 3'd3;
  localparam logic [2:0] CMD_WRITE8  = 3'd5;
  localparam logic [2:0] CMD_WRITE16 = 3'd6;
  localparam logic [2:0] CMD_WRITE32 = 3'd7;
  localparam logic [2:0] CMD_RESP    = 3'd7;

  localparam logic [3:0] LAST_WAIT = 4'(RESP_DELAY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR2 = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP1 = 3'd3,
    ST_RESP2 = 3'd4
  } state_t;

  state_t                   state_r, state_s;
  logic [2:0]               cmd_r, cmd_s;
  logic [14:0]              tagset_r, tagset_s;
  logic [15:0]              data_lo_r, data_lo_s;
  logic [15:0]              data_hi_r, data_hi_s;
  logic [MEM_ADDR_BITS-1:0] addr_r, addr_s;
  logic [3:0]               wait_cnt_r, wait_cnt_s;
  logic                     drive_r, drive_s;
  logic [2:0]               c1_r, c1_s;
  logic [15:0]              d1_r, d1_s;
  logic                     busy_r, busy_s;

  logic [7:0]               mem_r [0:MEM_BYTES-1];

  logic [18:0]              addr_full_s;
  logic [MEM_ADDR_BITS-1:0] addr_p1_s, addr_p2_s, addr_p3_s;
  logic                     wait_last_s, commit_s, is_read_s;
  logic [15:0]              rd_lo_s, rd_hi_s;
  logic                     unused_s;

  // Narrow accesses are naturally aligned, so the byte neighbours never cross the top of memory.
  function automatic logic [MEM_ADDR_BITS-1:0] align_addr(input logic [2:0] cmd,
                                                          input logic [MEM_ADDR_BITS-1:0] a);
    logic [MEM_ADDR_BITS-1:0] r;
    r = a;
    case (cmd)
      CMD_READ16, CMD_WRITE16: r[0] = 1'b0;
      CMD_READ32, CMD_WRITE32: r[1:0] = 2'b00;
      default:                 r = a;
    endcase
    return r;
  endfunction

  assign addr_full_s = {tagset_r, A1[3:0]};
  assign unused_s    = ^{addr_full_s[18:MEM_ADDR_BITS], A1[14:4]};
  assign addr_p1_s   = {addr_r[MEM_ADDR_BITS-1:1], 1'b1};
  assign addr_p2_s   = {addr_r[MEM_ADDR_BITS-1:2], 2'b10};
  assign addr_p3_s   = {addr_r[MEM_ADDR_BITS-1:2], 2'b11};

  assign wait_last_s = (wait_cnt_r == LAST_WAIT);
  assign is_read_s   = !cmd_r[2] && (cmd_r[1:0] != 2'b00);
  assign commit_s    = (state_r == ST_WAIT) && wait_last_s && cmd_r[2] && (cmd_r[1:0] != 2'b00);

  assign rd_lo_s = (cmd_r == CMD_READ8) ? {8'h00, mem_r[addr_r]}
                                        : {mem_r[addr_p1_s], mem_r[addr_r]};
  assign rd_hi_s = {mem_r[addr_p3_s], mem_r[addr_p2_s]};

  assign C1   = drive_r ? c1_r : 3'bzzz;
  assign D1   = drive_r ? d1_r : 16'hzzzz;
  assign busy = busy_r;

  // Next-state and next-output logic for the bus FSM.
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    tagset_s   = tagset_r;
    data_lo_s  = data_lo_r;
    data_hi_s  = data_hi_r;
    addr_s     = addr_r;
    wait_cnt_s = wait_cnt_r;
    drive_s    = drive_r;
    c1_s       = c1_r;
    d1_s       = d1_r;
    busy_s     = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (C1 != CMD_NOP) begin
          cmd_s     = C1;
          tagset_s  = A1;
          data_lo_s = D1;
          busy_s    = 1'b1;
          state_s   = ST_ADDR2;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR2: begin
        data_hi_s  = D1;
        addr_s     = align_addr(cmd_r, addr_full_s[MEM_ADDR_BITS-1:0]);
        wait_cnt_s = 4'd0;
        drive_s    = 1'b1;
        c1_s       = CMD_NOP;
        d1_s       = 16'h0000;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_last_s) begin
          c1_s    = CMD_RESP;
          d1_s    = is_read_s ? rd_lo_s : 16'h0000;
          state_s = ST_RESP1;
        end else begin
          wait_cnt_s = wait_cnt_r + 4'd1;
        end
      end
      ST_RESP1: begin
        if (cmd_r == CMD_READ32) begin
          d1_s    = rd_hi_s;
          state_s = ST_RESP2;
        end else begin
          drive_s = 1'b0;
          c1_s    = CMD_NOP;
          d1_s    = 16'h0000;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
      end
      ST_RESP2: begin
        drive_s = 1'b0;
        c1_s    = CMD_NOP;
        d1_s    = 16'h0000;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        drive_s = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, capture and output registers; reset wins over a simultaneous command.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      cmd_r      <= CMD_NOP;
      tagset_r   <= 15'd0;
      data_lo_r  <= 16'h0000;
      data_hi_r  <= 16'h0000;
      addr_r     <= '0;
      wait_cnt_r <= 4'd0;
      drive_r    <= 1'b0;
      c1_r       <= CMD_NOP;
      d1_r       <= 16'h0000;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      tagset_r   <= tagset_s;
      data_lo_r  <= data_lo_s;
      data_hi_r  <= data_hi_s;
      addr_r     <= addr_s;
      wait_cnt_r <= wait_cnt_s;
      drive_r    <= drive_s;
      c1_r       <= c1_s;
      d1_r       <= d1_s;
      busy_r     <= busy_s;
    end
  end

  // Little-endian write commit on the last WAIT cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!RESET && commit_s) begin
      case (cmd_r)
        CMD_WRITE8: mem_r[addr_r] <= data_lo_r[7:0];
        CMD_WRITE16: begin
          mem_r[addr_r]    <= data_lo_r[7:0];
          mem_r[addr_p1_s] <= data_lo_r[15:8];
        end
        CMD_WRITE32: begin
          mem_r[addr_r]    <= data_lo_r[7:0];
          mem_r[addr_p1_s] <= data_lo_r[15:8];
          mem_r[addr_p2_s] <= data_hi_r[7:0];
          mem_r[addr_p3_s] <= data_hi_r[15:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: expected RESPONSE words are queued when a command
// is issued (from a byte model of the scratchpad) and popped as the responder answers.
module tb_cpu_bus_responder;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        RESET;
  logic [14:0] A1;
  logic [2:0]  tb_c1;
  logic [15:0] tb_d1;
  logic        tb_drv;
  wire  [2:0]  C1;
  wire  [15:0] D1;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  model_mem [0:4095];

  assign C1 = tb_drv ? tb_c1 : 3'bzzz;
  assign D1 = tb_drv ? tb_d1 : 16'hzzzz;

  always #5 clk = ~clk;

  cpu_bus_responder #(.MEM_ADDR_BITS(12), .RESP_DELAY(RD)) dut (
    .clk(clk), .RESET(RESET), .A1(A1), .C1(C1), .D1(D1), .busy(busy)
  );

  // Drive a two-cycle command, queue its expected responses and update the model if it commits.
  task automatic issue(input logic [2:0] cmd, input logic [18:0] addr,
                       input logic [15:0] lo, input logic [15:0] hi, input bit apply);
    logic [11:0] a;
    a = addr[11:0];
    if (cmd == 3'd2 || cmd == 3'd6) a[0] = 1'b0;
    if (cmd == 3'd3 || cmd == 3'd7) a[1:0] = 2'b00;
    case (cmd)
      3'd1: exp_q.push_back({8'h00, model_mem[a]});
      3'd2: exp_q.push_back({model_mem[a + 12'd1], model_mem[a]});
      3'd3: begin
        exp_q.push_back({model_mem[a + 12'd1], model_mem[a]});
        exp_q.push_back({model_mem[a + 12'd3], model_mem[a + 12'd2]});
      end
      default: exp_q.push_back(16'h0000);
    endcase
    if (apply) begin
      if (cmd == 3'd5) model_mem[a] = lo[7:0];
      if (cmd == 3'd6 || cmd == 3'd7) begin
        model_mem[a] = lo[7:0];
        model_mem[a + 12'd1] = lo[15:8];
      end
      if (cmd == 3'd7) begin
        model_mem[a + 12'd2] = hi[7:0];
        model_mem[a + 12'd3] = hi[15:8];
      end
    end
    @(negedge clk);
    tb_drv = 1'b1; tb_c1 = cmd; A1 = addr[18:4]; tb_d1 = lo;
    @(negedge clk);
    tb_c1 = 3'd0; A1 = {11'd0, addr[3:0]}; tb_d1 = hi;
    @(negedge clk);
    tb_drv = 1'b0;
  endtask

  // Check RD NOP cycles, every queued RESPONSE, then bus release.
  task automatic expect_txn(input string name);
    logic [15:0] e;
    for (int i = 0; i < RD; i++) begin
      #1;
      n_cmp++;
      if ({C1, D1, busy} !== {3'd0, 16'h0000, 1'b1}) begin
        n_fail++;
        $display("FAIL %s wait%0d: C1=%h D1=%h busy=%b, required C1=0 D1=0000 busy=1", name, i, C1, D1, busy);
      end
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      n_cmp++;
      if ({C1, D1, busy} !== {3'd7, e, 1'b1}) begin
        n_fail++;
        $display("FAIL %s resp: C1=%h D1=%h busy=%b, required C1=7 D1=%h busy=1", name, C1, D1, busy, e);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (busy !== 1'b0 || !(C1 === 3'bzzz || C1 === 3'b000) || !(D1 === 16'hzzzz || D1 === 16'h0000)) begin
      n_fail++;
      $display("FAIL %s release: C1=%h D1=%h busy=%b, required released and busy=0", name, C1, D1, busy);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; tb_drv = 1'b0; tb_c1 = 3'd0; tb_d1 = 16'h0000; A1 = 15'd0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || !(C1 === 3'bzzz || C1 === 3'b000)) begin
      n_fail++;
      $display("FAIL reset_state: C1=%h busy=%b, required released and busy=0", C1, busy);
    end
  endtask

  task automatic test_write_read32();
    issue(3'd7, 19'h00104, 16'hBEEF, 16'hDEAD, 1'b1);
    expect_txn("write32");
    issue(3'd3, 19'h00104, 16'h0000, 16'h0000, 1'b1);
    expect_txn("read32");
  endtask

  task automatic test_narrow_reads();
    issue(3'd1, 19'h00106, 16'h0000, 16'h0000, 1'b1);
    expect_txn("read8_off6");
    issue(3'd2, 19'h00105, 16'h0000, 16'h0000, 1'b1);
    expect_txn("read16_off5");
  endtask

  task automatic test_wrap();
    issue(3'd5, 19'h00FFF, 16'h775A, 16'h0000, 1'b1);
    expect_txn("write8_top");
    issue(3'd1, 19'h01FFF, 16'h0000, 16'h0000, 1'b1);
    expect_txn("read8_wrap");
  endtask

  task automatic test_invalidate();
    issue(3'd4, 19'h00104, 16'h1111, 16'h2222, 1'b1);
    expect_txn("invalidate");
    issue(3'd3, 19'h00104, 16'h0000, 16'h0000, 1'b1);
    expect_txn("reread32");
  endtask

  task automatic test_reset_mid_write();
    issue(3'd7, 19'h00200, 16'h0000, 16'h0000, 1'b1);
    expect_txn("clear200");
    issue(3'd6, 19'h00200, 16'h1234, 16'h0000, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (busy !== 1'b1 || C1 !== 3'd0) begin
        n_fail++;
        $display("FAIL abort_wait%0d: C1=%h busy=%b, required C1=0 busy=1", i, C1, busy);
      end
      @(negedge clk);
    end
    RESET = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || !(C1 === 3'bzzz || C1 === 3'b000) || !(D1 === 16'hzzzz || D1 === 16'h0000)) begin
      n_fail++;
      $display("FAIL abort_release: C1=%h D1=%h busy=%b, required released and busy=0", C1, D1, busy);
    end
    RESET = 1'b0;
    issue(3'd2, 19'h00200, 16'h0000, 16'h0000, 1'b1);
    expect_txn("read16_after_abort");
  endtask

  task automatic test_reset_vs_command();
    @(negedge clk);
    RESET = 1'b1; tb_drv = 1'b1; tb_c1 = 3'd2; A1 = 15'h0010; tb_d1 = 16'h0000;
    @(negedge clk);
    RESET = 1'b0; tb_c1 = 3'd0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins: busy=%b, required 0", busy);
    end
    @(negedge clk);
    tb_drv = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_cmd: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    issue(3'd6, 19'h00302, 16'hA55A, 16'h0000, 1'b1);
    expect_txn("b2b_write16");
    issue(3'd2, 19'h00303, 16'h0000, 16'h0000, 1'b1);
    expect_txn("b2b_read16");
    issue(3'd1, 19'h00303, 16'h0000, 16'h0000, 1'b1);
    expect_txn("b2b_read8");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    test_reset();
    test_write_read32();
    test_narrow_reads();
    test_wrap();
    test_invalidate();
    test_reset_mid_write();
    test_reset_vs_command();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
